// File: rtl/hzd_sb.sv
// hzd_sb: hazard scoreboard and operand forwarding for the in-order pipeline.
// Tracks in-flight destinations from EX (stage 0) to WB (stage DEPTH-1) and
// resolves RAW hazards for the instruction sitting in ID.
//
// Ports:
//   clk, rst (async, active-high)
//   id_valid, id_rs1/2, id_rs1/2_en, id_rd, id_wr : instruction in ID
//   adv, flush                                     : pipeline movement
//   res_vld[DEPTH], res_data[DEPTH*XLEN]           : per-stage results
//   id_stall, fwd1/2_hit, fwd1/2_data              : hazard resolution
//   inflight, stall_cnt                            : status
//
// Build option: define RV6_HZD_FWD_EN to enable forwarding. When it is not
// defined every hazard stalls and the result inputs are ignored.

module hzd_sb #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       id_valid,
   input  logic [4:0]                 id_rs1,
   input  logic [4:0]                 id_rs2,
   input  logic                       id_rs1_en,
   input  logic                       id_rs2_en,
   input  logic [4:0]                 id_rd,
   input  logic                       id_wr,
   input  logic                       adv,
   input  logic                       flush,
   input  logic [DEPTH-1:0]           res_vld,
   input  logic [DEPTH*XLEN-1:0]      res_data,
   output logic                       id_stall,
   output logic                       fwd1_hit,
   output logic                       fwd2_hit,
   output logic [XLEN-1:0]            fwd1_data,
   output logic [XLEN-1:0]            fwd2_data,
   output logic [$clog2(DEPTH+1)-1:0] inflight,
   output logic [31:0]                stall_cnt
);

   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0] v_q;
   logic [4:0]       rd_q [DEPTH];

   logic m1, m2;
   logic st1, st2;
   logic ins;

`ifdef RV6_HZD_FWD_EN
   logic            v1, v2;
   logic [XLEN-1:0] d1, d2;
`endif

   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      m1 = 1'b0;
      m2 = 1'b0;
`ifdef RV6_HZD_FWD_EN
      v1 = 1'b0;
      v2 = 1'b0;
      d1 = '0;
      d2 = '0;
`endif
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (id_rs1_en && id_rs1 != 5'd0 && v_q[i] && rd_q[i] == id_rs1) begin
            m1 = 1'b1;
`ifdef RV6_HZD_FWD_EN
            v1 = res_vld[i];
            d1 = res_data[i*XLEN +: XLEN];
`endif
         end
         if (id_rs2_en && id_rs2 != 5'd0 && v_q[i] && rd_q[i] == id_rs2) begin
            m2 = 1'b1;
`ifdef RV6_HZD_FWD_EN
            v2 = res_vld[i];
            d2 = res_data[i*XLEN +: XLEN];
`endif
         end
      end
   end

`ifdef RV6_HZD_FWD_EN
   assign st1       = m1 & ~v1;
   assign st2       = m2 & ~v2;
   assign fwd1_hit  = m1 & v1;
   assign fwd2_hit  = m2 & v2;
   assign fwd1_data = fwd1_hit ? d1 : '0;
   assign fwd2_data = fwd2_hit ? d2 : '0;
`else
   logic unused_res;
   assign unused_res = ^{res_vld, res_data};
   assign st1        = m1;
   assign st2        = m2;
   assign fwd1_hit   = 1'b0;
   assign fwd2_hit   = 1'b0;
   assign fwd1_data  = '0;
   assign fwd2_data  = '0;
`endif

   assign id_stall = id_valid & (st1 | st2);

   // A stalled or flushed ID slot enters EX as a bubble.
   assign ins = id_valid & id_wr & (id_rd != 5'd0) & ~id_stall & ~flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         for (int i = 0; i < DEPTH; i++) rd_q[i] <= 5'd0;
      end else if (adv) begin
         for (int i = 1; i < DEPTH; i++) begin
            v_q[i]  <= v_q[i-1];
            rd_q[i] <= rd_q[i-1];
         end
         v_q[0]  <= ins;
         rd_q[0] <= id_rd;
      end else if (flush) begin
         v_q[0] <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (id_stall && stall_cnt != 32'hFFFF_FFFF)
         stall_cnt <= stall_cnt + 32'd1;
   end

   always_comb begin
      inflight = '0;
      for (int i = 0; i < DEPTH; i++)
         inflight = inflight + CW'(v_q[i]);
   end

endmodule
